// File: rtl/solitaire_turn_ctrl_if.sv
// Handshake bundle between the turn sequencer, the player I/O block and the
// move / talon-stock engines.
//   in_*  : player move request (valid/ready plus source, offset, destination)
//   mv_*  : move-engine launch pulse, latched move fields, completion/status
//   ts_*  : talon/stock draw request pulse and completion
// Modport slave is the sequencer's view; master is the surrounding logic.
interface solitaire_turn_ctrl_if;
  localparam int unsigned PILE_W = 4;

  logic              in_valid;
  logic              in_ready;
  logic [PILE_W-1:0] in_source;
  logic [PILE_W-1:0] in_offset;
  logic [PILE_W-1:0] in_dest;

  logic              mv_start;
  logic [PILE_W-1:0] mv_source;
  logic [PILE_W-1:0] mv_offset;
  logic [PILE_W-1:0] mv_dest;
  logic              mv_done;
  logic              mv_successful;

  logic              ts_check;
  logic              ts_done;

  modport slave (
    input  in_valid, in_source, in_offset, in_dest,
    output in_ready,
    output mv_start, mv_source, mv_offset, mv_dest,
    input  mv_done, mv_successful,
    output ts_check,
    input  ts_done
  );

  modport master (
    output in_valid, in_source, in_offset, in_dest,
    input  in_ready,
    input  mv_start, mv_source, mv_offset, mv_dest,
    output mv_done, mv_successful,
    input  ts_check,
    output ts_done
  );
endinterface

// File: rtl/solitaire_turn_ctrl.sv
// Turn sequencer: accepts one player move at a time, launches either the move
// engine or a stock draw, waits for completion, keeps move/reject statistics
// and checks the foundation for a win after each card move.
// Optional feature macro: SOL_MOVE_TIMEOUT_EN (per-operation watchdog).
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   setup_ready_i      deal complete (level)
//   bus_if             handshake bundle (slave modport): in_*, mv_*, ts_*
//   foundation_cards_i four foundation tops, 7 bits each
//   game_won_o         sticky win flag
//   busy_o             move or draw in flight
//   move_count_o       successful moves plus draws (saturating)
//   reject_count_o     illegal or timed-out moves (saturating)
//   timeout_err_o      sticky watchdog flag (0 without the macro)
module solitaire_turn_ctrl #(
  parameter int unsigned CNT_W = 10
`ifdef SOL_MOVE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    setup_ready_i,
  solitaire_turn_ctrl_if.slave    bus_if,
  input  logic [27:0]             foundation_cards_i,
  output logic                    game_won_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        move_count_o,
  output logic [CNT_W-1:0]        reject_count_o,
  output logic                    timeout_err_o
);

  localparam int unsigned PILE_W = 4;
  // Kings of H, C, D, S, all face up.
  localparam logic [27:0] ALL_KINGS = 28'b1100001_1100011_1100101_1100111;

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_MOVE,
    ST_WAIT_DRAW,
    ST_CHECK,
    ST_WON
  } state_e;

  state_e              state_q;
  logic [PILE_W-1:0]   src_q;
  logic [PILE_W-1:0]   off_q;
  logic [PILE_W-1:0]   dst_q;
  logic [CNT_W-1:0]    move_count_q;
  logic [CNT_W-1:0]    reject_count_q;
  logic [CNT_W-1:0]    move_count_d;
  logic [CNT_W-1:0]    reject_count_d;
  logic                game_won_q;

  // Saturating increments of the statistics counters.
  assign move_count_d   = (move_count_q == '1)   ? move_count_q   : move_count_q + CNT_W'(1);
  assign reject_count_d = (reject_count_q == '1) ? reject_count_q : reject_count_q + CNT_W'(1);

`ifdef SOL_MOVE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt_q;
  logic            timeout_err_q;
  logic            wait_expired;

  // Last waiting cycle before the watchdog fires.
  assign wait_expired  = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  // Sequencer state, latched move fields, counters and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_SETUP;
      src_q          <= '0;
      off_q          <= '0;
      dst_q          <= '0;
      move_count_q   <= '0;
      reject_count_q <= '0;
      game_won_q     <= 1'b0;
`ifdef SOL_MOVE_TIMEOUT_EN
      wait_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else if ((state_q != ST_WON) && !setup_ready_i) begin
      // Losing the deal abandons any in-flight operation; statistics survive.
      state_q <= ST_SETUP;
    end else begin
      unique case (state_q)
        ST_SETUP: state_q <= ST_IDLE;

        ST_IDLE: begin
          if (bus_if.in_valid) begin
            src_q   <= bus_if.in_source;
            off_q   <= bus_if.in_offset;
            dst_q   <= bus_if.in_dest;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state_q <= (src_q == '0) ? ST_WAIT_DRAW : ST_WAIT_MOVE;
`ifdef SOL_MOVE_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end

        ST_WAIT_MOVE: begin
          if (bus_if.mv_done) begin
            if (bus_if.mv_successful) move_count_q <= move_count_d;
            else                      reject_count_q <= reject_count_d;
            state_q <= ST_CHECK;
          end
`ifdef SOL_MOVE_TIMEOUT_EN
          else if (wait_expired) begin
            timeout_err_q  <= 1'b1;
            reject_count_q <= reject_count_d;
            state_q        <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
`endif
        end

        // A draw cannot change the foundation, so no win check follows it.
        ST_WAIT_DRAW: begin
          if (bus_if.ts_done) begin
            move_count_q <= move_count_d;
            state_q      <= ST_IDLE;
          end
`ifdef SOL_MOVE_TIMEOUT_EN
          else if (wait_expired) begin
            timeout_err_q  <= 1'b1;
            reject_count_q <= reject_count_d;
            state_q        <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
`endif
        end

        ST_CHECK: begin
          if (foundation_cards_i == ALL_KINGS) begin
            game_won_q <= 1'b1;
            state_q    <= ST_WON;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_WON: state_q <= ST_WON;

        default: state_q <= ST_SETUP;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign bus_if.in_ready  = (state_q == ST_IDLE);
  assign bus_if.mv_start  = (state_q == ST_ISSUE) && (src_q != '0);
  assign bus_if.ts_check  = (state_q == ST_ISSUE) && (src_q == '0);
  assign bus_if.mv_source = src_q;
  assign bus_if.mv_offset = off_q;
  assign bus_if.mv_dest   = dst_q;

  assign busy_o = (state_q == ST_ISSUE) || (state_q == ST_WAIT_MOVE) ||
                  (state_q == ST_WAIT_DRAW) || (state_q == ST_CHECK);

  assign game_won_o     = game_won_q;
  assign move_count_o   = move_count_q;
  assign reject_count_o = reject_count_q;

endmodule

// File: tb/tb_solitaire_turn_ctrl.sv
// Self-checking bench for solitaire_turn_ctrl: table vectors, hand-written
// corner sequences and randomized turns against a turn-level model.
module tb_solitaire_turn_ctrl;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [27:0] KINGS = 28'b1100001_1100011_1100101_1100111;

  logic          clk = 1'b0;
  logic          rst;
  logic          setup_ready;
  logic [27:0]   foundation;
  logic          game_won;
  logic          busy;
  logic [CW-1:0] move_count;
  logic [CW-1:0] reject_count;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_moves = 0;
  int exp_rej   = 0;

  solitaire_turn_ctrl_if bus();

  solitaire_turn_ctrl #(
    .CNT_W(CW)
`ifdef SOL_MOVE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .setup_ready_i      (setup_ready),
    .bus_if             (bus),
    .foundation_cards_i (foundation),
    .game_won_o         (game_won),
    .busy_o             (busy),
    .move_count_o       (move_count),
    .reject_count_o     (reject_count),
    .timeout_err_o      (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  off;
    logic [3:0]  dst;
    int          dly;
    logic        succ;
    logic [27:0] fnd;
    logic        glitch;
    int          dmove;
    int          drej;
    logic        won;
  } vec_t;

  vec_t vecs[5];

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
  endtask

  // One complete turn; done arrives in the dly-th waiting cycle.
  task automatic do_turn(input logic [3:0] src, input logic [3:0] off, input logic [3:0] dst,
                         input int dly, input logic succ, input logic [27:0] fnd,
                         input logic glitch, input int dmove, input int drej, input logic won);
    foundation = fnd;
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_source = src;
    bus.in_offset = off;
    bus.in_dest   = dst;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mv_start_pulse", 32'(bus.mv_start), 32'(src != 4'd0));
    chk("ts_check_pulse", 32'(bus.ts_check), 32'(src == 4'd0));
    chk("mv_fields", 32'({bus.mv_source, bus.mv_offset, bus.mv_dest}), 32'({src, off, dst}));
    chk("busy_issue", 32'(busy), 1);
    chk("ready_issue", 32'(bus.in_ready), 0);
    if (glitch) begin
      bus.mv_done       = 1'b1;
      bus.ts_done       = 1'b1;
      bus.mv_successful = 1'b1;
    end
    for (int c = 1; c <= dly; c++) begin
      @(negedge clk);
      bus.mv_done = 1'b0;
      bus.ts_done = 1'b0;
      if (c == 1) chk("pulse_one_cycle", 32'({bus.mv_start, bus.ts_check}), 0);
      chk("busy_wait", 32'(busy), 1);
    end
    if (src == 4'd0) bus.ts_done = 1'b1;
    else begin
      bus.mv_done       = 1'b1;
      bus.mv_successful = succ;
    end
    @(negedge clk);
    bus.mv_done = 1'b0;
    bus.ts_done = 1'b0;
    exp_moves = sat(exp_moves + dmove);
    exp_rej   = sat(exp_rej + drej);
    chk("move_count", 32'(move_count), 32'(exp_moves));
    chk("reject_count", 32'(reject_count), 32'(exp_rej));
    if (src != 4'd0) begin
      chk("check_busy", 32'(busy), 1);
      chk("check_not_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    chk("ready_after", 32'(bus.in_ready), 32'(!won));
    chk("game_won", 32'(game_won), 32'(won));
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    logic [3:0]  r_src, r_off, r_dst;
    logic [27:0] r_fnd;
    logic        r_succ, r_glitch;
    int          r_dm, r_dr;

    vecs[0] = '{src:4'd3,  off:4'd2,  dst:4'd5, dly:3, succ:1'b1, fnd:28'h0,       glitch:1'b0, dmove:1, drej:0, won:1'b0};
    vecs[1] = '{src:4'd7,  off:4'd0,  dst:4'd9, dly:1, succ:1'b0, fnd:28'h0,       glitch:1'b1, dmove:0, drej:1, won:1'b0};
    vecs[2] = '{src:4'd0,  off:4'd0,  dst:4'd0, dly:2, succ:1'b0, fnd:28'h0,       glitch:1'b1, dmove:1, drej:0, won:1'b0};
    vecs[3] = '{src:4'd12, off:4'd15, dst:4'd1, dly:4, succ:1'b1, fnd:KINGS ^ 28'h1, glitch:1'b0, dmove:1, drej:0, won:1'b0};
    vecs[4] = '{src:4'd0,  off:4'd6,  dst:4'd2, dly:1, succ:1'b1, fnd:KINGS,       glitch:1'b0, dmove:1, drej:0, won:1'b0};

    rst = 1'b1;
    setup_ready = 1'b0;
    foundation = '0;
    bus.in_valid = 1'b0;
    bus.in_source = '0;
    bus.in_offset = '0;
    bus.in_dest = '0;
    bus.mv_done = 1'b0;
    bus.mv_successful = 1'b0;
    bus.ts_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_pulses", 32'({bus.mv_start, bus.ts_check}), 0);
    chk("rst_fields", 32'({bus.mv_source, bus.mv_offset, bus.mv_dest}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_won", 32'(game_won), 0);
    chk("rst_counts", 32'({move_count, reject_count}), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("setup_hold", 32'(bus.in_ready), 0);
    setup_ready = 1'b1;
    @(negedge clk);
    chk("setup_to_idle", 32'(bus.in_ready), 1);

    for (int i = 0; i < 5; i++)
      do_turn(vecs[i].src, vecs[i].off, vecs[i].dst, vecs[i].dly, vecs[i].succ, vecs[i].fnd,
              vecs[i].glitch, vecs[i].dmove, vecs[i].drej, vecs[i].won);

    // Drop setup_ready mid-move: back to SETUP, counters kept, late done ignored.
    foundation = '0;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_source = 4'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    setup_ready = 1'b0;
    @(negedge clk);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_ready", 32'(bus.in_ready), 0);
    bus.mv_done = 1'b1;
    bus.mv_successful = 1'b1;
    @(negedge clk);
    bus.mv_done = 1'b0;
    chk("drop_moves", 32'(move_count), 32'(exp_moves));
    chk("drop_rej", 32'(reject_count), 32'(exp_rej));
    setup_ready = 1'b1;
    @(negedge clk);
    chk("drop_resume", 32'(bus.in_ready), 1);

    // Reset mid-draw: everything cleared, late ts_done ignored.
    bus.in_valid = 1'b1;
    bus.in_source = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_moves = 0;
    exp_rej = 0;
    chk("midrst_counts", 32'({move_count, reject_count}), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_fields", 32'({bus.mv_source, bus.mv_offset, bus.mv_dest}), 0);
    bus.ts_done = 1'b1;
    @(negedge clk);
    bus.ts_done = 1'b0;
    chk("midrst_ready", 32'(bus.in_ready), 1);
    chk("midrst_late_done", 32'(move_count), 0);

`ifdef SOL_MOVE_TIMEOUT_EN
    // Watchdog: no done for 8 waiting cycles.
    bus.in_valid = 1'b1;
    bus.in_source = 4'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    chk("to_not_yet", 32'(timeout_err), 0);
    chk("to_busy", 32'(busy), 1);
    @(negedge clk);
    exp_rej = sat(exp_rej + 1);
    chk("to_flag", 32'(timeout_err), 1);
    chk("to_rej", 32'(reject_count), 32'(exp_rej));
    chk("to_ready", 32'(bus.in_ready), 1);
`endif

    // Randomized turns against the turn-level model (counters saturate).
    for (int t = 0; t < 40; t++) begin
      r_src = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r_off = 4'($urandom);
      r_dst = 4'($urandom);
      r_succ = ($urandom_range(0, 3) != 0);
      r_glitch = 1'($urandom);
      r_fnd = 28'($urandom);
      if (r_fnd == KINGS) r_fnd = ~KINGS;
      r_dm = (r_src == 4'd0 || r_succ) ? 1 : 0;
      r_dr = 1 - r_dm;
      do_turn(r_src, r_off, r_dst, $urandom_range(1, 5), r_succ, r_fnd, r_glitch, r_dm, r_dr, 1'b0);
    end

`ifndef SOL_MOVE_TIMEOUT_EN
    chk("timeout_tied", 32'(timeout_err), 0);
`endif

    // Win: all kings after a successful move; WON ignores requests and setup loss.
    do_turn(4'd5, 4'd1, 4'd2, 2, 1'b1, KINGS, 1'b0, 1, 0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_source = 4'd3;
    setup_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("won_no_ready", 32'(bus.in_ready), 0);
      chk("won_no_pulse", 32'({bus.mv_start, bus.ts_check}), 0);
      chk("won_sticky", 32'(game_won), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("won_cleared", 32'(game_won), 0);
    chk("won_rst_counts", 32'({move_count, reject_count}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/solitaire_turn_ctrl.md
# solitaire_turn_ctrl

Turn sequencer for the solitaire datapath. Gates player move requests into the card-move engine and the talon/stock block one at a time, waits for each to complete, keeps move statistics, and checks the foundation for a win after every turn. Sits between the player I/O block and the `moveCard` / `talon_stock` blocks inside `solitaire`, after `setup` reports ready.

## Interface
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles for one move or draw; only used with `SOL_MOVE_TIMEOUT_EN`.
- `CNT_W`, 10: width of the move and reject counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `setup_ready`  in  1  deal complete; level signal.
- `in_valid`  in  1  player move available.
- `in_ready`  out  1  controller accepts a move.
- `in_source`  in  4  source pile code. 0 means stock draw.
- `in_offset`  in  4  card offset within the source pile.
- `in_dest`  in  4  destination pile code.
- `mv_start`  out  1  one-cycle pulse that launches the move engine.
- `mv_source`  out  4  registered copy of `in_source`.
- `mv_offset`  out  4  registered copy of `in_offset`.
- `mv_dest`  out  4  registered copy of `in_dest`.
- `mv_done`  in  1  move engine finished.
- `mv_successful`  in  1  move was legal; sampled together with `mv_done`.
- `ts_check`  out  1  one-cycle pulse that requests a stock→talon draw or recycle.
- `ts_done`  in  1  talon/stock operation finished.
- `foundation_cards`  in  28  foundation tops, 4 × 7 bits: {rank[3:0], suit[1:0], visible}.
- `game_won`  out  1  sticky win flag.
- `busy`  out  1  a move or draw is in flight.
- `move_count`  out  CNT_W  number of successful moves plus draws.
- `reject_count`  out  CNT_W  number of illegal or timed-out moves.
- `timeout_err`  out  1  sticky watchdog flag. Tied to 0 without the macro.

## Operation
- States: SETUP, IDLE, ISSUE, WAIT_MOVE, WAIT_DRAW, CHECK, WON.
- SETUP → IDLE when `setup_ready` = 1.
- In any state except WON, `setup_ready` = 0 returns the FSM to SETUP. The in-flight operation is abandoned; counters are kept.
- IDLE:
  - `in_ready` = 1 only in this state.
  - A handshake (`in_valid` & `in_ready`) latches source, offset and dest into the `mv_*` registers, then goes to ISSUE.
- ISSUE:
  - Lasts one cycle.
  - If the latched source is 0: pulse `ts_check`, go to WAIT_DRAW.
  - Otherwise: pulse `mv_start`, go to WAIT_MOVE.
- WAIT_MOVE:
  - Wait for `mv_done`.
  - On `mv_done`: if `mv_successful`, `move_count` += 1; else `reject_count` += 1. Then go to CHECK.
- WAIT_DRAW:
  - On `ts_done`: `move_count` += 1, go to IDLE. No win check is needed, because a draw cannot change the foundation.
- CHECK:
  - Lasts one cycle.
  - If `foundation_cards` = 28'b1100001_1100011_1100101_1100111 (kings of H, C, D, S, all visible): set `game_won`, go to WON.
  - Otherwise go to IDLE.
- WON: terminal. `in_ready` = 0 and no pulses are issued; only `rst` leaves this state.
- Counters saturate at all-ones and never wrap.
- `busy` = 1 in ISSUE, WAIT_MOVE, WAIT_DRAW and CHECK.
- `mv_done` and `ts_done` are ignored outside their own wait states, including in the same cycle as the launching pulse.

## Timing
- Reset values: state SETUP. Every output is 0: `in_ready`, `mv_start`, `mv_*` fields, `ts_check`, `game_won`, `busy`, both counters, `timeout_err`.
- Every output is registered or decoded from the state register; there is no combinational path from inputs to outputs.
- The `mv_start` or `ts_check` pulse is high in the cycle after the accepting handshake (one-cycle latency).
- Completion is seen on `mv_done` at edge N:
  - Counter update and CHECK are in cycle N+1.
  - `in_ready` returns, or `game_won` rises, in cycle N+2.
- Minimum turn length from handshake to the next `in_ready` is 4 cycles, assuming `done` arrives in the cycle after the pulse.
- `rst` mid-move clears everything on the next edge. Any late `done` from the engines is then ignored, because the FSM is in SETUP.

## Configuration
- `SOL_MOVE_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_MOVE and WAIT_DRAW; it is cleared on entry to either state.
  - If it reaches `TIMEOUT_CYCLES` with no `done`: set `timeout_err` (sticky until `rst`), `reject_count` += 1, go to IDLE.
  - If `done` and the timeout occur in the same cycle, `done` wins.
- `SOL_MOVE_TIMEOUT_EN` undefined:
  - No counter logic is built and `timeout_err` is constant 0.
  - The FSM waits in WAIT_MOVE or WAIT_DRAW indefinitely.

## Test plan
- Reset then `setup_ready` = 1 → `in_ready` = 1 one cycle later; all counters 0.
- Move src=3, off=2, dst=5; `mv_done` & `mv_successful` three cycles after `mv_start` → `mv_start` one cycle after the handshake with fields 3/2/5; `move_count` = 1; `in_ready` back 2 cycles after `mv_done`.
- Move with `mv_successful` = 0 → `reject_count` = 1, `move_count` unchanged. Also drive `mv_done` high during ISSUE → it is ignored.
- src=0 → `ts_check` pulse and no `mv_start`; `ts_done` → `move_count` += 1 with no CHECK cycle.
- Foundation preset to the all-kings value and any successful move → `game_won` = 1 and `in_ready` stays 0 while `in_valid` is held high; `rst` clears the win.
- With `SOL_MOVE_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, and `mv_done` never asserted → `timeout_err` = 1 after 8 WAIT cycles, `reject_count` = 1, back to IDLE. Separately, drop `setup_ready` mid-move → SETUP, counters unchanged.
